// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller.
//   NUM_REGS   : architectural register count (r0-r15)
//   REG_PC     : r15, the PC, which is never hazarded
//   reg_addr_t : 4-bit register address
package decode_hazard_ctrl_pkg;

   localparam int unsigned NUM_REGS = 16;

   typedef logic [3:0] reg_addr_t;

   localparam reg_addr_t REG_PC = 4'd15;

endpackage

// File: rtl/decode_hazard_ctrl_sb_counter.sv
// Single scoreboard entry: a CNT_W-bit count of in-flight writes to one register.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   inc        : an instruction writing this register issues
//   dec_a      : writeback release (applied first)
//   dec_b      : squash release (applied only if a count remains after dec_a)
//   cnt        : current count
//   zero, full : count == 0 / count == all-ones
//   underflow  : one-cycle pulse, a release was dropped on a zero count
module sb_counter #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec_a,
   input  logic             dec_b,
   output logic [CNT_W-1:0] cnt,
   output logic             zero,
   output logic             full,
   output logic             underflow
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] after_a;
   logic             dec_a_ok;
   logic             dec_b_ok;

   // Releases are ordered: writeback first, then squash against what is left.
   // The issue increment is added last so an issue plus release nets to zero.
   always_comb begin
      dec_a_ok  = dec_a & (cnt_q != '0);
      after_a   = cnt_q - CNT_W'(dec_a_ok);
      dec_b_ok  = dec_b & (after_a != '0);
      cnt_nxt   = after_a - CNT_W'(dec_b_ok) + CNT_W'(inc);
      underflow = (dec_a & ~dec_a_ok) | (dec_b & ~dec_b_ok);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_nxt;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);
   assign full = (cnt_q == '1);

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Scoreboard stall controller for the decode stage.
// Ports:
//   clk, reset                   : clock, asynchronous active-low reset
//   d_valid                      : decode holds a valid instruction
//   ra1/ra2, ra1_used/ra2_used   : source addresses and read enables
//   wa3, wr_used                 : destination address and write enable
//   wb_en, wb_addr               : writeback release (RegWrite/WA3 at W)
//   kill_en, kill_addr           : squashed-writer release
//   d_ready                      : instruction issues this cycle
//   stall_fd                     : hold F and D pipeline registers
//   pending                      : per-register nonzero flags (bit 15 = 0)
//   stall_cnt                    : saturating stall-cycle count
//   underflow                    : sticky, a release hit a zero count
module decode_hazard_ctrl
   import decode_hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W     = 2,
   parameter int unsigned WB_BYPASS = 1,
   parameter int unsigned PERF_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              d_valid,
   input  reg_addr_t         ra1,
   input  reg_addr_t         ra2,
   input  logic              ra1_used,
   input  logic              ra2_used,
   input  reg_addr_t         wa3,
   input  logic              wr_used,
   input  logic              wb_en,
   input  reg_addr_t         wb_addr,
   input  logic              kill_en,
   input  reg_addr_t         kill_addr,
   output logic              d_ready,
   output logic              stall_fd,
   output logic [15:0]       pending,
   output logic [PERF_W-1:0] stall_cnt,
   output logic              underflow
);

   logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
   logic [NUM_REGS-1:0]            zero;
   logic [NUM_REGS-1:0]            full;
   logic [NUM_REGS-2:0]            uf_pulse;
   logic                           haz1;
   logic                           haz2;
   logic                           dst_full;
   logic                           underflow_q;
   logic [PERF_W-1:0]              stall_cnt_q;

   function automatic logic src_haz(input logic             used,
                                    input reg_addr_t        a,
                                    input logic [CNT_W-1:0] c,
                                    input logic             wb_hit);
      logic bypass;
      bypass  = (WB_BYPASS != 0) && wb_hit && (c == CNT_W'(1));
      src_haz = used && (a != REG_PC) && (c != '0) && !bypass;
   endfunction

   // r15 has no counter: it reads as always zero and ignores issue/release.
   assign cnt[REG_PC]  = '0;
   assign zero[REG_PC] = 1'b1;
   assign full[REG_PC] = 1'b0;

   for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_sb
      sb_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .inc       (d_ready && wr_used && (wa3 == reg_addr_t'(i))),
         .dec_a     (wb_en && (wb_addr == reg_addr_t'(i))),
         .dec_b     (kill_en && (kill_addr == reg_addr_t'(i))),
         .cnt       (cnt[i]),
         .zero      (zero[i]),
         .full      (full[i]),
         .underflow (uf_pulse[i])
      );
   end

   // A same-cycle writeback to the destination frees a slot, so a full
   // register may still accept the new issue (counter nets to unchanged).
   always_comb begin
      haz1     = src_haz(ra1_used, ra1, cnt[ra1], wb_en && (wb_addr == ra1));
      haz2     = src_haz(ra2_used, ra2, cnt[ra2], wb_en && (wb_addr == ra2));
      dst_full = wr_used && full[wa3] && !(wb_en && (wb_addr == wa3));
      d_ready  = reset && d_valid && !haz1 && !haz2 && !dst_full;
      stall_fd = reset && d_valid && !d_ready;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         underflow_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         underflow_q <= underflow_q | (|uf_pulse);
         if (stall_fd && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
      end
   end

   assign pending   = {1'b0, ~zero[NUM_REGS-2:0]};
   assign stall_cnt = stall_cnt_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
module tb_decode_hazard_ctrl;
   import decode_hazard_ctrl_pkg::*;

   logic      clk = 1'b0;
   logic      reset;
   logic      d_valid, ra1_used, ra2_used, wr_used, wb_en, kill_en;
   reg_addr_t ra1, ra2, wa3, wb_addr, kill_addr;

   logic        d_ready, stall_fd, underflow;
   logic [15:0] pending, stall_cnt;
   logic        d_ready4, stall_fd4, underflow4;
   logic [15:0] pending4;
   logic [3:0]  stall_cnt4;

   int unsigned passed = 0;
   int unsigned total  = 0;

   always #5 clk = ~clk;

   decode_hazard_ctrl #(.CNT_W(2), .WB_BYPASS(1), .PERF_W(16)) u_dut (
      .clk(clk), .reset(reset), .d_valid(d_valid),
      .ra1(ra1), .ra2(ra2), .ra1_used(ra1_used), .ra2_used(ra2_used),
      .wa3(wa3), .wr_used(wr_used), .wb_en(wb_en), .wb_addr(wb_addr),
      .kill_en(kill_en), .kill_addr(kill_addr),
      .d_ready(d_ready), .stall_fd(stall_fd), .pending(pending),
      .stall_cnt(stall_cnt), .underflow(underflow)
   );

   decode_hazard_ctrl #(.CNT_W(2), .WB_BYPASS(1), .PERF_W(4)) u_dut4 (
      .clk(clk), .reset(reset), .d_valid(d_valid),
      .ra1(ra1), .ra2(ra2), .ra1_used(ra1_used), .ra2_used(ra2_used),
      .wa3(wa3), .wr_used(wr_used), .wb_en(wb_en), .wb_addr(wb_addr),
      .kill_en(kill_en), .kill_addr(kill_addr),
      .d_ready(d_ready4), .stall_fd(stall_fd4), .pending(pending4),
      .stall_cnt(stall_cnt4), .underflow(underflow4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clr();
      d_valid = 0; ra1_used = 0; ra2_used = 0; wr_used = 0; wb_en = 0; kill_en = 0;
      ra1 = '0; ra2 = '0; wa3 = '0; wb_addr = '0; kill_addr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      reset = 1'b0;
      d_valid = 1'b1;
      #2;
      chk("rst_d_ready", d_ready, 0);
      chk("rst_stall_fd", stall_fd, 0);
      chk("rst_pending", pending, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_underflow", underflow, 0);
      @(negedge clk);
      reset = 1'b1;
      clr();
      tick();

      // RAW on r3 with writeback bypass
      d_valid = 1; wa3 = 3; wr_used = 1; #1;
      chk("t1_issue", d_ready, 1);
      tick();
      chk("t1_pend", pending, 16'h0008);
      clr(); d_valid = 1; ra1 = 3; ra1_used = 1; #1;
      chk("t1_raw_ready", d_ready, 0);
      chk("t1_raw_stall", stall_fd, 1);
      tick();
      chk("t1_stall_cnt", stall_cnt, 1);
      wb_en = 1; wb_addr = 3; #1;
      chk("t1_bypass_ready", d_ready, 1);
      chk("t1_bypass_stall", stall_fd, 0);
      tick();
      clr(); #1;
      chk("t1_released", pending, 0);

      // Destination counter capacity on r5
      for (int i = 0; i < 3; i++) begin
         clr(); d_valid = 1; wa3 = 5; wr_used = 1; #1;
         chk("t2_issue", d_ready, 1);
         tick();
      end
      chk("t2_pend", pending, 16'h0020);
      #1;
      chk("t2_full_stall", d_ready, 0);
      tick();
      wb_en = 1; wb_addr = 5; #1;
      chk("t2_wb_issue", d_ready, 1);
      tick();
      wb_en = 0; #1;
      chk("t2_still_full", d_ready, 0);
      tick();
      chk("t2_stall_cnt", stall_cnt, 3);
      clr(); wb_en = 1; wb_addr = 5;
      tick();
      tick();
      chk("t2_drain2", pending, 16'h0020);
      tick();
      clr();
      chk("t2_drain3", pending, 0);
      chk("t2_no_uf", underflow, 0);

      // r15 is never hazarded
      d_valid = 1; ra2 = 15; ra2_used = 1; wa3 = 15; wr_used = 1; #1;
      chk("t4_pc_ready", d_ready, 1);
      tick();
      clr();
      chk("t4_pc_pend", pending, 0);
      wb_en = 1; wb_addr = 15; kill_en = 1; kill_addr = 15;
      tick();
      clr();
      chk("t4_pc_uf", underflow, 0);
      chk("t4_pc_pend2", pending, 0);

      // Stall counting and saturation
      @(negedge clk);
      reset = 1'b0; #1;
      chk("rst2_stall_cnt", stall_cnt, 0);
      reset = 1'b1;
      tick();
      d_valid = 1; wa3 = 2; wr_used = 1; #1;
      chk("t5_issue", d_ready, 1);
      tick();
      clr(); d_valid = 1; ra1 = 2; ra1_used = 1; #1;
      chk("t5_stall", stall_fd, 1);
      repeat (5) tick();
      chk("t5_cnt5", stall_cnt, 5);
      chk("t5_cnt5_w4", stall_cnt4, 5);
      repeat (12) tick();
      chk("t5_cnt17", stall_cnt, 17);
      chk("t5_sat_w4", stall_cnt4, 15);
      wb_en = 1; wb_addr = 2; #1;
      chk("t5_release", d_ready, 1);
      chk("t5_release_w4", d_ready4, 1);
      tick();
      clr();
      chk("t5_pend", pending, 0);
      chk("t5_cnt_hold", stall_cnt, 17);

      // Simultaneous writeback and squash on r7
      d_valid = 1; wa3 = 7; wr_used = 1;
      tick();
      tick();
      clr();
      chk("t3_pend", pending, 16'h0080);
      wb_en = 1; wb_addr = 7; kill_en = 1; kill_addr = 7;
      tick();
      clr();
      chk("t3_two_rel", pending, 0);
      chk("t3_no_uf", underflow, 0);
      d_valid = 1; wa3 = 7; wr_used = 1;
      tick();
      clr(); wb_en = 1; wb_addr = 7; kill_en = 1; kill_addr = 7;
      tick();
      clr();
      chk("t3_one_rel", pending, 0);
      chk("t3_uf", underflow, 1);
      chk("t3_uf_w4", underflow4, 1);

      // Asynchronous reset mid-stall
      d_valid = 1; wa3 = 4; wr_used = 1;
      tick();
      tick();
      clr(); d_valid = 1; ra1 = 4; ra1_used = 1; #1;
      chk("t6_stall", stall_fd, 1);
      tick();
      #2;
      reset = 1'b0; #1;
      chk("t6_rst_ready", d_ready, 0);
      chk("t6_rst_stall", stall_fd, 0);
      chk("t6_rst_pend", pending, 0);
      chk("t6_rst_cnt", stall_cnt, 0);
      chk("t6_rst_uf", underflow, 0);
      reset = 1'b1; #1;
      chk("t6_issue", d_ready, 1);
      tick();
      clr();
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
